// File: rtl/seg14_pkg.sv
// Shared types and the hex -> 14-segment (+DP) table for the scan controller.
package seg14_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam int SEG_DP_BIT = 15;

    // Bit 15 is left clear in every entry; the decimal point is merged in downstream.
    localparam logic [15:0] HEX_SEG_0 = 16'h3AB1;
    localparam logic [15:0] HEX_SEG_1 = 16'h0290;
    localparam logic [15:0] HEX_SEG_2 = 16'h3161;
    localparam logic [15:0] HEX_SEG_3 = 16'h30D1;
    localparam logic [15:0] HEX_SEG_4 = 16'h0A50;
    localparam logic [15:0] HEX_SEG_5 = 16'h38C1;
    localparam logic [15:0] HEX_SEG_6 = 16'h39E1;
    localparam logic [15:0] HEX_SEG_7 = 16'h1090;
    localparam logic [15:0] HEX_SEG_8 = 16'h3BF1;
    localparam logic [15:0] HEX_SEG_9 = 16'h3AD1;
    localparam logic [15:0] HEX_SEG_A = 16'h1BF0;
    localparam logic [15:0] HEX_SEG_B = 16'h3ED4;
    localparam logic [15:0] HEX_SEG_C = 16'h2821;
    localparam logic [15:0] HEX_SEG_D = 16'h36B4;
    localparam logic [15:0] HEX_SEG_E = 16'h3961;
    localparam logic [15:0] HEX_SEG_F = 16'h1861;

    function automatic logic [15:0] hex_seg(input logic [3:0] nib);
        logic [15:0] s;
        case (nib)
            4'h0:    s = HEX_SEG_0;
            4'h1:    s = HEX_SEG_1;
            4'h2:    s = HEX_SEG_2;
            4'h3:    s = HEX_SEG_3;
            4'h4:    s = HEX_SEG_4;
            4'h5:    s = HEX_SEG_5;
            4'h6:    s = HEX_SEG_6;
            4'h7:    s = HEX_SEG_7;
            4'h8:    s = HEX_SEG_8;
            4'h9:    s = HEX_SEG_9;
            4'hA:    s = HEX_SEG_A;
            4'hB:    s = HEX_SEG_B;
            4'hC:    s = HEX_SEG_C;
            4'hD:    s = HEX_SEG_D;
            4'hE:    s = HEX_SEG_E;
            default: s = HEX_SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg14_scan_ctrl_if.sv
// Host-side controls and pin-side outputs of the scan controller, plus FSM state for observation.
interface seg14_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
    import seg14_pkg::*;

    // load is a single-cycle strobe with no back-pressure: value_in/dp_in are taken on
    // every cycle load=1, and a newer strobe replaces any not-yet-displayed value.
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_blank;
    logic [15:0]             seg_out;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_tick;
    state_t                  dbg_state;

    modport master (
        output enable, load, value_in, dp_in, lz_blank,
        input  seg_out, dig_en, frame_tick, dbg_state
    );

    modport slave (
        input  enable, load, value_in, dp_in, lz_blank,
        output seg_out, dig_en, frame_tick, dbg_state
    );
endinterface

// File: rtl/seg14_hex_lut.sv
// Combinational nibble -> 16-bit segment word lookup.
module seg14_hex_lut
    import seg14_pkg::*;
(
    input  logic [3:0]  nibble,
    output logic [15:0] seg
);
    assign seg = hex_seg(nibble);
endmodule

// File: rtl/seg14_scan_ctrl.sv
// Time-multiplexed 14-segment scan driver: one digit per slot, each slot opening with
// an all-off gap so the digit enable never moves while segments are lit.
module seg14_scan_ctrl
    import seg14_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 100,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
)
(
    input logic              clk,
    input logic              rst,
    seg14_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [15:0]           SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 16'hFFFF : 16'h0000;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CW-1:0]         BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]         SLOT_END  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    frame_d, copy_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, disp_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;
    logic                    pend_valid_q;
    logic [15:0]             seg_q;
    logic [NUM_DIGITS-1:0]   dig_q;
    logic                    frame_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        frame_d = 1'b0;
        copy_d  = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    copy_d  = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_END) state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt_q == SLOT_END) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                            copy_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // lz_mask[i]: every nibble from the top down to digit i is zero.
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (disp_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    logic [3:0]  cur_nib;
    logic [15:0] lut_seg;
    assign cur_nib = disp_val_q[{idx_q, 2'b00} +: 4];

    seg14_hex_lut u_lut (
        .nibble (cur_nib),
        .seg    (lut_seg)
    );

    // Suppressed leading zeros lose their segments but still show their decimal point.
    logic [15:0]           seg_raw;
    logic [NUM_DIGITS-1:0] dig_raw;
    always_comb begin
        seg_raw = '0;
        dig_raw = '0;
        if (bus.enable && state_q == ST_SHOW) begin
            dig_raw[idx_q]      = 1'b1;
            seg_raw             = lut_seg;
            seg_raw[SEG_DP_BIT] = disp_dp_q[idx_q];
            if (bus.lz_blank && lz_mask[idx_q]) seg_raw[14:0] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            frame_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            seg_q   <= seg_raw ^ SEG_OFF;
            dig_q   <= dig_raw ^ DIG_OFF;
            if (copy_d && pend_valid_q) begin
                disp_val_q <= pend_val_q;
                disp_dp_q  <= pend_dp_q;
            end
            // A strobe on the copy cycle is kept pending for the next frame.
            if (bus.load) begin
                pend_val_q   <= bus.value_in;
                pend_dp_q    <= bus.dp_in;
                pend_valid_q <= 1'b1;
            end else if (copy_d) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dig_en     = dig_q;
    assign bus.frame_tick = frame_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_seg14_scan_ctrl.sv
// Directed bench: instance a uses default polarity, instance b has active-low segments
// and active-high digit enables and mirrors a's inputs.
module tb_seg14_scan_ctrl;
    import seg14_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg14_scan_ctrl_if #(.NUM_DIGITS(4)) ifa ();
    seg14_scan_ctrl_if #(.NUM_DIGITS(4)) ifb ();

    assign ifb.enable   = ifa.enable;
    assign ifb.load     = ifa.load;
    assign ifb.value_in = ifa.value_in;
    assign ifb.dp_in    = ifa.dp_in;
    assign ifb.lz_blank = ifa.lz_blank;

    seg14_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    seg14_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2),
                      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_assert = 0;
    int n_fail   = 0;
    int now      = -1;
    int ft_cnt   = 0;
    int ft_mark  = 0;
    bit mon_on   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] s, input logic [3:0] d);
        check({tag, "_seg"}, 32'(ifa.seg_out), 32'(s));
        check({tag, "_dig"}, 32'(ifa.dig_en), 32'(d));
    endtask

    task automatic go(input int e);
        while (now < e) begin
            @(posedge clk);
            #1;
            now++;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        ifa.load     = 1'b1;
        ifa.value_in = v;
        ifa.dp_in    = dp;
        go(now + 1);
        ifa.load     = 1'b0;
    endtask

    // Per-cycle properties: one-hot enables, dark during BLANK, enables move only when dark.
    state_t      st_prev;
    logic [15:0] seg_prev = 16'h0000;
    logic [3:0]  dig_prev = 4'hF;
    always @(posedge clk) st_prev <= ifa.dbg_state;
    always @(negedge clk) begin
        if (ifa.frame_tick === 1'b1) ft_cnt++;
        if (mon_on) begin
            check("onehot_a", 32'($onehot0(~ifa.dig_en)), 32'd1);
            check("onehot_b", 32'($onehot0(ifb.dig_en)), 32'd1);
            if (st_prev == ST_BLANK) check("blank_dark", 32'(ifa.seg_out), 32'h0);
            if (ifa.dig_en !== dig_prev)
                check("dig_move_dark", 32'(ifa.seg_out == 16'h0 || seg_prev == 16'h0), 32'd1);
            seg_prev = ifa.seg_out;
            dig_prev = ifa.dig_en;
        end
    end

    initial begin
        ifa.enable   = 1'b0;
        ifa.load     = 1'b0;
        ifa.value_in = '0;
        ifa.dp_in    = '0;
        ifa.lz_blank = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk_out("rst_a", 16'h0000, 4'hF);
        check("rst_ft", 32'(ifa.frame_tick), 32'd0);
        check("rst_state", 32'(ifa.dbg_state), 32'(ST_IDLE));
        check("rst_b_seg", 32'(ifb.seg_out), 32'hFFFF);
        check("rst_b_dig", 32'(ifb.dig_en), 32'h0);
        rst    = 1'b0;
        mon_on = 1'b1;

        // Basic scan of 10F0, no blanking
        do_load(16'h10F0, 4'b0000);
        ifa.enable = 1'b1;
        now = -1;
        go(0);   check("e0_state", 32'(ifa.dbg_state), 32'(ST_BLANK));
                 check("e0_ft", 32'(ifa.frame_tick), 32'd0);
                 chk_out("e0", 16'h0000, 4'hF);
        go(2);   chk_out("e2_off", 16'h0000, 4'hF);
        go(3);   chk_out("d0_first", 16'h3AB1, 4'hE);
        go(8);   chk_out("d0_last", 16'h3AB1, 4'hE);
        go(9);   chk_out("d1_gap", 16'h0000, 4'hF);
        go(11);  chk_out("d1", 16'h1861, 4'hD);
        go(19);  chk_out("d2", 16'h3AB1, 4'hB);
        go(27);  chk_out("d3", 16'h0290, 4'h7);
        go(31);  check("ft_before", 32'(ifa.frame_tick), 32'd0);
        go(32);  check("ft_wrap", 32'(ifa.frame_tick), 32'd1);
        go(33);  check("ft_after", 32'(ifa.frame_tick), 32'd0);
                 check("ft_count1", 32'(ft_cnt), 32'd1);

        // Leading-zero suppression of 0001
        go(40);  ifa.lz_blank = 1'b1;
                 do_load(16'h0001, 4'b0000);
        go(64);  check("ft_frame2", 32'(ifa.frame_tick), 32'd1);
        go(67);  check("ft_count2", 32'(ft_cnt), 32'd2);
                 chk_out("lz_d0", 16'h0290, 4'hE);
        go(75);  chk_out("lz_d1", 16'h0000, 4'hD);
        go(83);  chk_out("lz_d2", 16'h0000, 4'hB);
        go(91);  chk_out("lz_d3", 16'h0000, 4'h7);
        go(92);  do_load(16'h0001, 4'b0100);
        go(99);  chk_out("lzdp_d0", 16'h0290, 4'hE);
        go(107); chk_out("lzdp_d1", 16'h0000, 4'hD);
        go(115); chk_out("lzdp_d2", 16'h8000, 4'hB);
        go(123); chk_out("lzdp_d3", 16'h0000, 4'h7);
        go(124); ifa.lz_blank = 1'b0;

        // Mid-frame load is held until the next frame
        go(131); chk_out("f4_d0", 16'h0290, 4'hE);
        go(139); chk_out("f4_d1", 16'h3AB1, 4'hD);
        go(147); chk_out("f4_d2", 16'hBAB1, 4'hB);
        go(148); do_load(16'hF1F0, 4'b0000);
        go(150); chk_out("tear_d2", 16'hBAB1, 4'hB);
        go(155); chk_out("tear_d3", 16'h3AB1, 4'h7);
        go(160); check("ft_f5", 32'(ifa.frame_tick), 32'd1);
        go(163); chk_out("f5_d0", 16'h3AB1, 4'hE);
        go(171); chk_out("f5_d1", 16'h1861, 4'hD);
        go(179); chk_out("f5_d2", 16'h0290, 4'hB);
        go(187); chk_out("f5_d3", 16'h1861, 4'h7);

        // Load on the copy cycle is deferred one frame
        go(188); do_load(16'h1111, 4'b0000);
        go(191); do_load(16'hFFFF, 4'b0000);
                 check("ft_copy", 32'(ifa.frame_tick), 32'd1);
        go(195); chk_out("f6_d0", 16'h0290, 4'hE);
        go(203); chk_out("f6_d1", 16'h0290, 4'hD);
        go(227); chk_out("f7_d0", 16'h1861, 4'hE);
        go(235); chk_out("f7_d1", 16'h1861, 4'hD);

        // Drop and restore enable
        ifa.enable = 1'b0;
        go(236); chk_out("dis", 16'h0000, 4'hF);
                 check("dis_state", 32'(ifa.dbg_state), 32'(ST_IDLE));
        go(237); ft_mark = ft_cnt;
                 ifa.enable = 1'b1;
        go(238); check("ren_state", 32'(ifa.dbg_state), 32'(ST_BLANK));
                 check("ren_ft", 32'(ifa.frame_tick), 32'd0);
        go(241); chk_out("ren_d0", 16'h1861, 4'hE);
                 check("ren_ft_cnt", 32'(ft_cnt), 32'(ft_mark));
                 check("ren_b_seg", 32'(ifb.seg_out), 32'hE79E);
                 check("ren_b_dig", 32'(ifb.dig_en), 32'h1);

        // Reset during SHOW clears the pending value
        do_load(16'h1111, 4'b0000);
        rst = 1'b1;
        go(243); chk_out("rst2", 16'h0000, 4'hF);
                 check("rst2_ft", 32'(ifa.frame_tick), 32'd0);
                 check("rst2_state", 32'(ifa.dbg_state), 32'(ST_IDLE));
                 check("rst2_b_seg", 32'(ifb.seg_out), 32'hFFFF);
                 check("rst2_b_dig", 32'(ifb.dig_en), 32'h0);
        rst = 1'b0;
        go(244); check("rst2_restart", 32'(ifa.dbg_state), 32'(ST_BLANK));
        go(247); chk_out("rst2_d0", 16'h3AB1, 4'hE);
                 check("rst2_b_d0_seg", 32'(ifb.seg_out), 32'hC54E);
                 check("rst2_b_d0_dig", 32'(ifb.dig_en), 32'h1);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
